// File: rtl/fetch_unit_pkg.sv
// Shared CPU types for the fetch stage: word/opcode types, the HALT opcode and the fetch FSM states.
package fetch_unit_pkg;

   typedef logic [31:0] word_t;
   typedef logic [5:0]  opcode_t;

   localparam opcode_t OP_HALT = 6'h3F;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HALT_PEND = 2'd1,
      HALTED    = 2'd2
   } fetch_state_t;

   function automatic opcode_t opcode_of(input word_t w);
      return w[31:26];
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register between instruction memory and decode.
// Flush beats load, load beats accept.
module fetch_buffer
   import fetch_unit_pkg::*;
(
   input  logic  CLK,
   input  logic  RST,
   input  logic  load_i,
   input  logic  accept_i,
   input  logic  flush_i,
   input  word_t data_i,
   output logic  valid_o,
   output word_t data_o
);

   logic  valid_q, valid_d;
   word_t data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (accept_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues memory reads, handles redirects and self-halts on HALT.
// Define FETCH_MISALIGN_EN to trap misaligned redirects (fault + halt) instead of truncating them.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter word_t RESET_PC = 32'h0000_0000
) (
   input  logic  CLK,
   input  logic  RST,
   output logic  iREN,
   output word_t iaddr,
   input  logic  ihit,
   input  word_t iload,
   output logic  instr_valid,
   output word_t instruction,
   input  logic  instr_ready,
   input  logic  redirect,
   input  word_t redirect_addr,
   output logic  halted,
   output logic  fault
);

   fetch_state_t state_q;
   word_t        pc_q;
   logic         acc, load, redir, misalign;
   word_t        redir_pc;

   // A halted core ignores redirects entirely, including the buffer flush.
   assign redir = redirect && (state_q != HALTED);
   assign acc   = instr_valid && instr_ready;
   assign iREN  = !RST && (state_q == RUN) && !redirect && (!instr_valid || instr_ready);
   assign load  = iREN && ihit;

`ifdef FETCH_MISALIGN_EN
   logic fault_q;
   assign misalign = (redirect_addr[1:0] != 2'b00);
   assign redir_pc = redirect_addr;
   assign fault    = fault_q;

   always_ff @(posedge CLK) begin
      if (RST)                   fault_q <= 1'b0;
      else if (redir && misalign) fault_q <= 1'b1;
   end
`else
   logic unused_addr_lo;
   assign unused_addr_lo = ^redirect_addr[1:0];
   assign misalign       = 1'b0;
   assign redir_pc       = {redirect_addr[31:2], 2'b00};
   assign fault          = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
      end else if (redir) begin
         if (misalign) begin
            state_q <= HALTED;
         end else begin
            state_q <= RUN;
            pc_q    <= redir_pc;
         end
      end else begin
         case (state_q)
            RUN: if (load) begin
               if (opcode_of(iload) == OP_HALT) state_q <= HALT_PEND;
               else                             pc_q    <= pc_q + 32'd4;
            end
            HALT_PEND: if (acc) state_q <= HALTED;
            default: ;
         endcase
      end
   end

   fetch_buffer u_buf (
      .CLK      (CLK),
      .RST      (RST),
      .load_i   (load),
      .accept_i (acc),
      .flush_i  (redir),
      .data_i   (iload),
      .valid_o  (instr_valid),
      .data_o   (instruction)
   );

   assign iaddr  = pc_q;
   assign halted = (state_q == HALTED);

endmodule
